// File: rtl/frv_asi_issue.sv
// frv_asi_issue: issues one held request (s_*) to the ASI unit (asi_*) and returns its result on r_*; define FRV_ASI_ISSUE_PERF_EN to add the stall_count output
module frv_asi_issue #(
  parameter int XL = 31,
  parameter int OP = 4
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        flush,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [OP:0] s_uop,
  input  logic [1:0]  s_shamt,
  input  logic [XL:0] s_rs1,
  input  logic [XL:0] s_rs2,
  input  logic [4:0]  s_rd,
  output logic        asi_valid,
  output logic [OP:0] asi_uop,
  output logic [XL:0] asi_rs1,
  output logic [XL:0] asi_rs2,
  output logic [1:0]  asi_shamt,
  input  logic        asi_ready,
  input  logic [XL:0] asi_result,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [XL:0] r_result,
  output logic [4:0]  r_rd
`ifdef FRV_ASI_ISSUE_PERF_EN
  ,
  output logic [31:0] stall_count
`endif
);
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, HOLD = 2'd2;
  logic [1:0]  state;
  logic        live;
  logic        idle, exec, hold, take;
  logic [OP:0] h_uop;
  logic [XL:0] h_rs1, h_rs2, h_res;
  logic [1:0]  h_shamt;
  logic [4:0]  h_rd;
  assign idle      = state == IDLE;
  assign exec      = state == EXEC;
  assign hold      = state == HOLD;
  assign s_ready   = live && (idle || (hold && r_ready));
  assign take      = s_valid && s_ready && !flush;
  assign asi_valid = exec;
  assign r_valid   = hold;
  always_comb begin
    asi_uop   = exec ? h_uop : '0;
    asi_rs1   = exec ? h_rs1 : '0;
    asi_rs2   = exec ? h_rs2 : '0;
    asi_shamt = exec ? h_shamt : '0;
    r_result  = hold ? h_res : '0;
    r_rd      = hold ? h_rd : '0;
  end
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state   <= IDLE;
      live    <= 1'b0;
      h_uop   <= '0;
      h_rs1   <= '0;
      h_rs2   <= '0;
      h_shamt <= '0;
      h_rd    <= '0;
      h_res   <= '0;
    end else begin
      live <= 1'b1;
      if (take) begin
        h_uop   <= s_uop;
        h_rs1   <= s_rs1;
        h_rs2   <= s_rs2;
        h_shamt <= s_shamt;
        h_rd    <= s_rd;
      end
      if (exec && asi_ready && !flush) h_res <= asi_result;
      state <= flush ? IDLE :
               take ? EXEC :
               (exec && asi_ready) ? HOLD :
               (hold && r_ready) ? IDLE : state;
    end
  end
`ifdef FRV_ASI_ISSUE_PERF_EN
  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) stall_count <= '0;
    else if (exec && !asi_ready) stall_count <= stall_count + 32'd1;
  end
`endif
endmodule

// File: doc/frv_asi_issue.md
FRV_ASI_ISSUE -- requirements
Module: frv_asi_issue

Interface
REQ-001 SHALL have parameter XL, default 31, giving the operand/result MSB index (XLEN = XL+1).
REQ-002 SHALL have parameter OP, default 4, giving the uop MSB index.
REQ-003 SHALL have port g_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port g_reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1 bit: pipeline flush that cancels any held operation.
REQ-006 SHALL have ports s_valid (input, 1 bit) and s_ready (output, 1 bit): the upstream request handshake.
REQ-007 SHALL have port s_uop, input, OP+1 bits, and port s_shamt, input, 2 bits.
REQ-008 SHALL have ports s_rs1 and s_rs2, each input, XL+1 bits, and port s_rd, input, 5 bits.
REQ-009 SHALL have port asi_valid, output, 1 bit: request to the ASI unit.
REQ-010 SHALL have output ports asi_uop (OP+1 bits), asi_rs1 (XL+1 bits), asi_rs2 (XL+1 bits) and asi_shamt (2 bits): the held operands.
REQ-011 SHALL have port asi_ready, input, 1 bit, and port asi_result, input, XL+1 bits: the ASI completion and its combinational result.
REQ-012 SHALL have ports r_valid (output, 1 bit) and r_ready (input, 1 bit): the downstream writeback handshake.
REQ-013 SHALL have port r_result, output, XL+1 bits, and port r_rd, output, 5 bits.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, EXEC, HOLD.
REQ-015 IDLE: s_ready=1; s_valid && !flush SHALL capture s_uop, s_rs1, s_rs2, s_shamt and s_rd into holding registers, next state EXEC.
REQ-016 EXEC: asi_valid=1 and s_ready=0; asi_* SHALL be driven from the holding registers and SHALL stay stable until asi_ready.
REQ-017 EXEC with asi_ready=1: asi_result SHALL be latched into r_result, next state HOLD.
REQ-018 EXEC with asi_ready=0: state SHALL remain EXEC with no cycle limit.
REQ-019 HOLD: r_valid=1 and r_result/r_rd SHALL be stable; s_ready SHALL equal r_ready.
REQ-020 HOLD with r_ready && s_valid: a new request SHALL be captured and the next state SHALL be EXEC (back-to-back, no bubble).
REQ-021 HOLD with r_ready && !s_valid: next state IDLE.
REQ-022 HOLD with !r_ready: state and outputs SHALL be unchanged.
REQ-023 Latency: capture at cycle N; asi_valid at N+1; asi_ready at cycle M≥N+1 gives r_valid at M+1.
REQ-024 Single-cycle ASI ops (SHA2/SHA3) SHALL therefore yield r_valid at N+2.
REQ-025 flush SHALL take priority over every transition: next state IDLE, no capture, and any r_valid or asi_valid SHALL drop on the next cycle.
REQ-026 When flush and asi_ready are simultaneous, the ASI result SHALL be discarded.
REQ-027 When not in EXEC, asi_uop/asi_rs1/asi_rs2/asi_shamt SHALL be driven to zero, so that operands are not exposed to the ASI gating.
REQ-028 When r_valid=0, r_result and r_rd SHALL read zero.

Reset
REQ-029 g_reset high SHALL asynchronously force state IDLE.
REQ-030 During reset, all holding registers and r_result SHALL be 0.
REQ-031 During reset, asi_valid=0, r_valid=0 and s_ready=0.
REQ-032 On the first clock edge after reset deasserts, s_ready SHALL become 1.
REQ-033 Reset asserted mid-EXEC or mid-HOLD SHALL abandon the operation with no r_valid pulse.

Configuration
REQ-034 Macro FRV_ASI_ISSUE_PERF_EN, when defined, SHALL add output stall_count (32 bits).
REQ-035 With FRV_ASI_ISSUE_PERF_EN defined, stall_count SHALL increment each cycle in EXEC with asi_ready=0, SHALL wrap 0xFFFFFFFF to 0, and SHALL reset to 0.
REQ-036 With FRV_ASI_ISSUE_PERF_EN undefined, the port and counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-037 SHA2 op: uop for sha256.s0, rs1=0x12345678, asi_ready tied to asi_valid, asi_result=0xE7FCE6EE at N+1 -> r_valid at N+2, r_result=0xE7FCE6EE, r_rd echoed.
REQ-038 Multi-cycle AES: asi_ready asserted 3 cycles after asi_valid -> asi_rs1/asi_rs2 constant across all 3 cycles; stall_count=+2 (PERF_EN); r_valid one cycle after asi_ready.
REQ-039 Back-to-back: two requests, r_ready=1 continuously, single-cycle ASI -> second asi_valid the cycle after the first r_valid; throughput of one result per 2 cycles.
REQ-040 Backpressure: r_ready=0 for 5 cycles in HOLD -> r_result unchanged and s_ready=0 throughout.
REQ-041 Flush coinciding with asi_ready in EXEC -> no r_valid next cycle; state IDLE; s_ready=1.
REQ-042 g_reset pulsed mid-EXEC (asynchronously, between edges) -> asi_valid=0 immediately; all outputs 0; stall_count=0.
